// File: rtl/up_arbiter_pkg.sv
// up_arbiter_pkg: shared state/op encodings and width helper for the uP arbiter
package up_arbiter_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_t;
  function automatic int clog2_min1(input int v);
    return v > 1 ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/up_rr_arbiter.sv
// up_rr_arbiter: combinational round-robin pick starting after the last winner
//   req   - request vector
//   last  - index of the previous winner
//   valid - any request present
//   idx   - first set request scanning upward from last+1 with wrap
module up_rr_arbiter
  import up_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int GW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic          valid,
  output logic [GW-1:0] idx
);
  // Scanning the distance downward lets the nearest requester win without a break.
  always_comb begin
    valid = |req;
    idx = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(last) + k) % N]) idx = GW'((int'(last) + k) % N);
  end
endmodule

// File: rtl/up_arbiter.sv
// up_arbiter: round-robin share of one uP register slave between several uP masters
//   clk, rstn             - clock, asynchronous active-low reset
//   s_up_*                - packed per-master read/write request ports, master 0 in LSBs
//   s_up_terr             - one-cycle timeout flag alongside the forced ack
//   m_up_*                - single slave-side read/write port
//   grant, busy           - current/last granted master, transaction in flight
module up_arbiter
  import up_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 4,
  parameter int NUM_MASTERS   = 2,
  parameter int TIMEOUT       = 255
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [NUM_MASTERS-1:0]               s_up_rreq,
  output logic [NUM_MASTERS-1:0]               s_up_rack,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] s_up_raddr,
  output logic [NUM_MASTERS*BUS_WIDTH*8-1:0]   s_up_rdata,
  input  logic [NUM_MASTERS-1:0]               s_up_wreq,
  output logic [NUM_MASTERS-1:0]               s_up_wack,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] s_up_waddr,
  input  logic [NUM_MASTERS*BUS_WIDTH*8-1:0]   s_up_wdata,
  output logic [NUM_MASTERS-1:0]               s_up_terr,
  output logic                                 m_up_rreq,
  input  logic                                 m_up_rack,
  output logic [ADDRESS_WIDTH-1:0]             m_up_raddr,
  input  logic [BUS_WIDTH*8-1:0]               m_up_rdata,
  output logic                                 m_up_wreq,
  input  logic                                 m_up_wack,
  output logic [ADDRESS_WIDTH-1:0]             m_up_waddr,
  output logic [BUS_WIDTH*8-1:0]               m_up_wdata,
  output logic [clog2_min1(NUM_MASTERS)-1:0]   grant,
  output logic                                 busy
);
  localparam int GW = clog2_min1(NUM_MASTERS);
  localparam int CW = clog2_min1(TIMEOUT + 1);
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = BUS_WIDTH * 8;
  state_t state;
  op_t op;
  logic [GW-1:0] last, pick;
  logic pick_v, req_live, ack_in, to;
  logic [CW-1:0] cnt;
  up_rr_arbiter #(.N(NUM_MASTERS), .GW(GW)) u_rr (
    .req  (s_up_rreq | s_up_wreq),
    .last (last),
    .valid(pick_v),
    .idx  (pick)
  );
  assign busy = state == BUSY;
  assign req_live = op == OP_READ ? s_up_rreq[grant] : s_up_wreq[grant];
  assign ack_in = op == OP_READ ? m_up_rack : m_up_wack;
  // A real ack in the last allowed cycle beats the forced completion.
  assign to = busy && req_live && !ack_in && TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
  assign m_up_rreq = busy && op == OP_READ && s_up_rreq[grant] && !to;
  assign m_up_wreq = busy && op == OP_WRITE && s_up_wreq[grant] && !to;
  assign m_up_raddr = busy ? s_up_raddr[grant*AW +: AW] : '0;
  assign m_up_waddr = busy ? s_up_waddr[grant*AW +: AW] : '0;
  assign m_up_wdata = busy ? s_up_wdata[grant*DW +: DW] : '0;
  always_comb begin
    s_up_rack = '0;
    s_up_wack = '0;
    s_up_terr = '0;
    s_up_rdata = '0;
    if (busy) begin
      s_up_rack[grant] = op == OP_READ && (m_up_rack || to);
      s_up_wack[grant] = op == OP_WRITE && (m_up_wack || to);
      s_up_terr[grant] = to;
      s_up_rdata[grant*DW +: DW] = to ? '0 : m_up_rdata;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      op <= OP_READ;
      grant <= '0;
      last <= GW'(NUM_MASTERS - 1);
      cnt <= '0;
    end else if (state == IDLE) begin
      if (pick_v) begin
        state <= BUSY;
        grant <= pick;
        last <= pick;
        op <= s_up_rreq[pick] ? OP_READ : OP_WRITE;
        cnt <= '0;
      end
    end else begin
      if (ack_in || !req_live || to) state <= IDLE;
      cnt <= &cnt ? cnt : cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_up_arbiter.sv
// tb_up_arbiter: scoreboard bench for up_arbiter with two masters and TIMEOUT=8
module tb_up_arbiter;
  localparam int NM = 2, AW = 16, DW = 32, TO = 8;
  logic clk = 0, rstn;
  logic [NM-1:0] s_up_rreq, s_up_rack, s_up_wreq, s_up_wack, s_up_terr;
  logic [NM*AW-1:0] s_up_raddr, s_up_waddr;
  logic [NM*DW-1:0] s_up_rdata, s_up_wdata;
  logic m_up_rreq, m_up_rack, m_up_wreq, m_up_wack, busy;
  logic [AW-1:0] m_up_raddr, m_up_waddr;
  logic [DW-1:0] m_up_rdata, m_up_wdata;
  logic [0:0] grant;

  up_arbiter #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(4), .NUM_MASTERS(NM), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .s_up_rreq(s_up_rreq), .s_up_rack(s_up_rack), .s_up_raddr(s_up_raddr), .s_up_rdata(s_up_rdata),
    .s_up_wreq(s_up_wreq), .s_up_wack(s_up_wack), .s_up_waddr(s_up_waddr), .s_up_wdata(s_up_wdata),
    .s_up_terr(s_up_terr),
    .m_up_rreq(m_up_rreq), .m_up_rack(m_up_rack), .m_up_raddr(m_up_raddr), .m_up_rdata(m_up_rdata),
    .m_up_wreq(m_up_wreq), .m_up_wack(m_up_wack), .m_up_waddr(m_up_waddr), .m_up_wdata(m_up_wdata),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int m; bit rd; logic [31:0] data; bit terr;} sb_t;
  typedef struct {bit rd; logic [15:0] addr; logic [31:0] wdata; logic [31:0] rdata; int delay;} sl_t;
  sb_t sb_q[$];
  sl_t sl_q[$];
  int n_chk = 0, n_fail = 0;
  logic [NM-1:0] la, lw;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Master side: sample acks mid-cycle, drop acked requests just after the next edge.
  task tick_a;
    @(negedge clk);
    la = s_up_rack;
    lw = s_up_wack;
  endtask
  task tick_b;
    @(posedge clk);
    #1;
    s_up_rreq &= ~la;
    s_up_wreq &= ~lw;
    la = '0;
    lw = '0;
  endtask

  task automatic rd(input int m, input logic [15:0] addr, input logic [31:0] data, input int delay, input bit terr);
    s_up_rreq[m] = 1'b1;
    s_up_raddr[m*AW +: AW] = addr;
    sl_q.push_back('{1'b1, addr, 32'h0, data, delay});
    sb_q.push_back('{m, 1'b1, terr ? 32'h0 : data, terr});
  endtask
  task automatic wr(input int m, input logic [15:0] addr, input logic [31:0] wdata, input int delay);
    s_up_wreq[m] = 1'b1;
    s_up_waddr[m*AW +: AW] = addr;
    s_up_wdata[m*DW +: DW] = wdata;
    sl_q.push_back('{1'b0, addr, wdata, 32'h0, delay});
    sb_q.push_back('{m, 1'b0, 32'h0, 1'b0});
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      tick_a;
      tick_b;
      if (sb_q.size() == 0 && s_up_rreq == 0 && s_up_wreq == 0 && !busy) break;
    end
    check({name, "_completes"}, i < budget, 1);
  endtask

  // Slave model: ack after a per-transaction number of BUSY cycles (0 = never).
  initial begin
    sl_t cur;
    bit active;
    int k;
    active = 0;
    k = 0;
    cur = '{1'b0, 16'h0, 32'h0, 32'h0, 0};
    m_up_rack = 0;
    m_up_wack = 0;
    m_up_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      m_up_rack = 0;
      m_up_wack = 0;
      m_up_rdata = '0;
      if (!busy) active = 0;
      else if (!active) begin
        active = 1;
        k = 1;
        check("slave_expected_txn", sl_q.size() != 0, 1);
        if (sl_q.size() != 0) cur = sl_q.pop_front();
        check("slave_rreq", m_up_rreq, cur.rd);
        check("slave_wreq", m_up_wreq, !cur.rd);
        check("slave_addr", cur.rd ? m_up_raddr : m_up_waddr, cur.addr);
        if (!cur.rd) check("slave_wdata", m_up_wdata, cur.wdata);
      end else k++;
      if (active && cur.delay != 0 && k == cur.delay) begin
        if (cur.rd) begin
          m_up_rack = 1;
          m_up_rdata = cur.rdata;
        end else m_up_wack = 1;
      end
    end
  end

  // Monitor: every ack the masters see is matched against the scoreboard.
  initial begin
    sb_t e;
    logic [NM-1:0] er, ew, et;
    logic [NM*DW-1:0] ed;
    forever begin
      @(negedge clk);
      check("no_req_overlap", m_up_rreq & m_up_wreq, 0);
      if (|s_up_rack || |s_up_wack) begin
        check("ack_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          er = '0; ew = '0; et = '0; ed = '0;
          er[e.m] = e.rd;
          ew[e.m] = !e.rd;
          et[e.m] = e.terr;
          ed[e.m*DW +: DW] = e.data;
          check("rack", s_up_rack, er);
          check("wack", s_up_wack, ew);
          check("terr", s_up_terr, et);
          check("rdata", s_up_rdata, ed);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin
    int bc;
    bit seen;
    rstn = 0;
    s_up_rreq = '0; s_up_wreq = '0;
    s_up_raddr = '0; s_up_waddr = '0; s_up_wdata = '0;
    la = '0; lw = '0;
    repeat (3) @(posedge clk);
    tick_a;
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_mreq", {m_up_rreq, m_up_wreq}, 0);
    check("rst_sacks", {s_up_rack, s_up_wack, s_up_terr}, 0);
    check("rst_rdata", s_up_rdata, 0);
    check("rst_maddr", {m_up_raddr, m_up_waddr, m_up_wdata}, 0);
    tick_b;
    rstn = 1;
    tick_a;
    tick_b;

    // Contention after reset: master 0 first, then alternate.
    wr(0, 16'h0004, 32'h11, 2);
    rd(1, 16'h0008, 32'hCAFE0001, 1, 0);
    wait_done("contention1", 40);
    wr(0, 16'h0104, 32'h22, 1);
    rd(1, 16'h0108, 32'hCAFE0002, 3, 0);
    wait_done("contention2", 40);

    // Single read: slave request one cycle after the master request.
    rd(0, 16'h0010, 32'hDEADBEEF, 3, 0);
    tick_a;
    check("lat_idle_cycle_rreq", m_up_rreq, 0);
    tick_b;
    tick_a;
    check("lat_next_cycle_rreq", m_up_rreq, 1);
    check("lat_raddr", m_up_raddr, 16'h0010);
    check("lat_grant", grant, 0);
    tick_b;
    wait_done("single_read", 40);

    // Same master read+write: read first, write at the next arbitration.
    rd(1, 16'h0200, 32'h0BADF00D, 2, 0);
    wr(1, 16'h0204, 32'h55, 2);
    wait_done("rd_wr_same", 40);

    // Timeout: master 0 never acked, master 1 waits its turn.
    rd(0, 16'h0020, 32'h0, 0, 1);
    rd(1, 16'h0030, 32'hA5A5A5A5, 2, 0);
    bc = 0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick_a;
      if (busy && grant == 0) bc++;
      if (s_up_rack[0]) begin
        seen = 1;
        check("to_busy_cycles", bc, 8);
        check("to_mreq_low", m_up_rreq, 0);
      end
      tick_b;
    end
    check("to_forced_ack_seen", seen, 1);
    wait_done("timeout", 40);

    // Real ack on the timeout cycle wins.
    rd(0, 16'h0040, 32'h12345678, 8, 0);
    wait_done("ack_at_timeout", 40);

    // Async reset mid-transaction.
    s_up_rreq[0] = 1'b1;
    s_up_raddr[0 +: AW] = 16'h0050;
    sl_q.push_back('{1'b1, 16'h0050, 32'h0, 32'h0, 0});
    tick_a;
    tick_b;
    tick_a;
    check("pre_reset_busy", {busy, m_up_rreq}, 2'b11);
    @(posedge clk);
    #3 rstn = 0;
    #1;
    check("areset_mreq", m_up_rreq, 0);
    check("areset_busy", busy, 0);
    check("areset_acks", {s_up_rack, s_up_wack}, 0);
    check("areset_grant", grant, 0);
    s_up_rreq = '0;
    @(posedge clk);
    #1 rstn = 1;
    wr(0, 16'h0064, 32'h77, 1);
    rd(1, 16'h0060, 32'h600D0001, 1, 0);
    wait_done("post_reset_priority", 40);

    repeat (3) begin
      tick_a;
      tick_b;
    end
    check("sb_drained", sb_q.size(), 0);
    check("slave_drained", sl_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
